// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB subordinate between two requesters,
// round-robin grant, SETUP/ACCESS sequencing and a wait-state timeout.
module apb_req_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int Timeout   = 16
) (
  input  logic                 clk,
  input  logic                 nReset,

  input  logic                 req0Valid,
  input  logic [AddrWidth-1:0] req0Addr,
  input  logic [DataWidth-1:0] req0WData,
  input  logic                 req0Write,
  output logic                 req0Ready,
  output logic                 rsp0Valid,
  output logic [DataWidth-1:0] rsp0RData,
  output logic                 rsp0Err,

  input  logic                 req1Valid,
  input  logic [AddrWidth-1:0] req1Addr,
  input  logic [DataWidth-1:0] req1WData,
  input  logic                 req1Write,
  output logic                 req1Ready,
  output logic                 rsp1Valid,
  output logic [DataWidth-1:0] rsp1RData,
  output logic                 rsp1Err,

  output logic [AddrWidth-1:0] addr,
  output logic [DataWidth-1:0] wData,
  output logic                 write,
  output logic                 sel,
  output logic                 enable,
  input  logic [DataWidth-1:0] rData,
  input  logic                 subErr,
  input  logic                 readyOut
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam int CntW =
    (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam int TmoLast =
    (Timeout > 0) ? Timeout - 1 : 0;
  localparam logic [CntW-1:0] CntLast =
    CntW'(TmoLast);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic TmoOn = (Timeout != 0);

  state_t state_q;
  state_t state_d;

  logic            lastGrant_q;
  logic [CntW-1:0] cnt_q;

  logic                 anyReq;
  logic                 win1;
  logic                 accept;
  logic                 done;
  logic                 tmo;
  logic                 finish;
  logic [DataWidth-1:0] rspD;
  logic                 rspE;

  assign anyReq = req0Valid | req1Valid;

  // req1 wins alone, or on a tie when req0 was granted last
  assign win1 = req1Valid
              & (~req0Valid | ~lastGrant_q);

  assign accept = nReset
                & (state_q == IDLE)
                & anyReq;

  assign req0Ready = accept & ~win1;
  assign req1Ready = accept &  win1;

  assign done = (state_q == ACCESS) & readyOut;

  // readyOut on the last allowed cycle still completes normally
  assign tmo = TmoOn
             & (state_q == ACCESS)
             & ~readyOut
             & (cnt_q == CntLast);

  assign finish = done | tmo;

  assign sel    = (state_q != IDLE);
  assign enable = (state_q == ACCESS);

  always_comb begin
    rspD = '0;
    rspE = 1'b0;
    unique case (1'b1)
      done: begin
        rspD = write ? '0 : rData;
        rspE = subErr;
      end
      tmo: begin
        rspE = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (anyReq) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      addr        <= '0;
      wData       <= '0;
      write       <= 1'b0;
      lastGrant_q <= 1'b1;
      cnt_q       <= '0;
      rsp0Valid   <= 1'b0;
      rsp0RData   <= '0;
      rsp0Err     <= 1'b0;
      rsp1Valid   <= 1'b0;
      rsp1RData   <= '0;
      rsp1Err     <= 1'b0;
    end else begin
      rsp0Valid <= 1'b0;
      rsp1Valid <= 1'b0;

      if (accept) begin
        addr        <= win1 ? req1Addr  : req0Addr;
        wData       <= win1 ? req1WData : req0WData;
        write       <= win1 ? req1Write : req0Write;
        lastGrant_q <= win1;
        cnt_q       <= '0;
      end

      if ((state_q == ACCESS) && !readyOut
          && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // lastGrant_q doubles as the owner of the bus transfer
      if (finish) begin
        if (lastGrant_q) begin
          rsp1Valid <= 1'b1;
          rsp1RData <= rspD;
          rsp1Err   <= rspE;
        end else begin
          rsp0Valid <= 1'b1;
          rsp0RData <= rspD;
          rsp0Err   <= rspE;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: scoreboard bench for apb_req_arbiter with a
// behavioural subordinate and a round-robin reference model.
module tb_apb_req_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    int            w;
    logic [DW-1:0] rd;
    logic          err;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic [1:0]    rv;
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rw [2];
  logic [1:0]    rwr;
  logic          r0rdy, r1rdy;
  logic          s0v, s1v;
  logic [DW-1:0] s0d, s1d;
  logic          s0e, s1e;
  logic [AW-1:0] addr;
  logic [DW-1:0] wData;
  logic [DW-1:0] rData;
  logic          write, sel, enable;
  logic          subErr, readyOut;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_g = 1;

  plan_t pend [2];
  plan_t plan_q [$];
  exp_t  exp_q0 [$];
  exp_t  exp_q1 [$];
  int    grants [$];

  apb_req_arbiter #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .Timeout(TMO)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .req0Valid(rv[0]),
    .req0Addr(ra[0]),
    .req0WData(rw[0]),
    .req0Write(rwr[0]),
    .req0Ready(r0rdy),
    .rsp0Valid(s0v),
    .rsp0RData(s0d),
    .rsp0Err(s0e),
    .req1Valid(rv[1]),
    .req1Addr(ra[1]),
    .req1WData(rw[1]),
    .req1Write(rwr[1]),
    .req1Ready(r1rdy),
    .rsp1Valid(s1v),
    .rsp1RData(s1d),
    .rsp1Err(s1e),
    .addr(addr),
    .wData(wData),
    .write(write),
    .sel(sel),
    .enable(enable),
    .rData(rData),
    .subErr(subErr),
    .readyOut(readyOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // ACCESS cycles minus one: wait states, capped by the timeout
  function automatic int eff_w(input plan_t p);
    return (p.w >= TMO) ? TMO - 1 : p.w;
  endfunction

  task automatic accept_push(input int n);
    plan_t p;
    exp_t  e;
    logic  to;
    p = pend[n];
    to = (p.w >= TMO);
    plan_q.push_back(p);
    e.cyc = cyc + 1 + 2 + eff_w(p);
    e.err = to ? 1'b1 : p.err;
    e.rd  = (to || p.write) ? '0 : p.rd;
    if (n == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    grants.push_back(n);
    last_g = n;
  endtask

  task automatic raise(input int n,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic wr,
                       input int w,
                       input logic [DW-1:0] rd,
                       input logic err);
    pend[n].addr  = a;
    pend[n].wdata = d;
    pend[n].write = wr;
    pend[n].w     = w;
    pend[n].rd    = rd;
    pend[n].err   = err;
    ra[n]  = a;
    rw[n]  = d;
    rwr[n] = wr;
    rv[n]  = 1'b1;
  endtask

  task automatic rand_raise(input int n);
    int w;
    if ($urandom_range(0, 6) == 0) w = $urandom_range(TMO, TMO + 3);
    else                           w = $urandom_range(0, TMO - 1);
    raise(n, $urandom, $urandom, 1'($urandom_range(0, 1)),
          w, $urandom, 1'($urandom_range(0, 3) == 0));
  endtask

  // one clock: arbitration check at negedge, drive after posedge
  task automatic step();
    logic [1:0] acc;
    logic [1:0] er;
    @(negedge clk);
    er = 2'b00;
    if (nReset && !sel) begin
      if (rv[0] && (!rv[1] || last_g == 1)) er = 2'b01;
      else if (rv[1])                       er = 2'b10;
    end
    chk("ready", {r1rdy, r0rdy}, er);
    acc = rv & {r1rdy, r0rdy};
    for (int n = 0; n < 2; n++) if (acc[n]) accept_push(n);
    @(posedge clk);
    #1;
    rv = rv & ~acc;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((rv != 0 || exp_q0.size() != 0 || exp_q1.size() != 0
            || sel) && i < budget) begin
      step();
      i++;
    end
    chk("drain_budget", i < budget, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (s0v) begin
      if (exp_q0.size() == 0) chk("rsp0_owner", s0v, 1'b0);
      else begin
        e = exp_q0.pop_front();
        chk("rsp0_rdata", s0d, e.rd);
        chk("rsp0_err", s0e, e.err);
        chk("rsp0_cycle", cyc, e.cyc);
      end
    end else if (exp_q0.size() != 0 && exp_q0[0].cyc <= cyc) begin
      chk("rsp0_missing", s0v, 1'b1);
      void'(exp_q0.pop_front());
    end
    if (s1v) begin
      if (exp_q1.size() == 0) chk("rsp1_owner", s1v, 1'b0);
      else begin
        e = exp_q1.pop_front();
        chk("rsp1_rdata", s1d, e.rd);
        chk("rsp1_err", s1e, e.err);
        chk("rsp1_cycle", cyc, e.cyc);
      end
    end else if (exp_q1.size() != 0 && exp_q1[0].cyc <= cyc) begin
      chk("rsp1_missing", s1v, 1'b1);
      void'(exp_q1.pop_front());
    end
  end

  plan_t cur;
  int    k = 0;
  int    enRun = 0;
  logic  curValid = 1'b0;

  // behavioural subordinate: garbage outside the completing edge
  always @(negedge clk) begin
    readyOut = 1'($urandom);
    rData    = $urandom;
    subErr   = 1'($urandom);
    if (!nReset) begin
      enRun = 0;
      curValid = 1'b0;
    end else if (sel && !enable) begin
      if (plan_q.size() == 0) chk("setup_unplanned", sel, 1'b0);
      else begin
        cur = plan_q.pop_front();
        curValid = 1'b1;
        k = 0;
        enRun = 0;
        chk("paddr", addr, cur.addr);
        chk("pwdata", wData, cur.wdata);
        chk("pwrite", write, cur.write);
      end
    end else if (sel && enable) begin
      enRun++;
      if (curValid && k == cur.w) begin
        readyOut = 1'b1;
        rData    = cur.rd;
        subErr   = cur.err;
      end else begin
        readyOut = 1'b0;
      end
      k++;
    end else if (curValid) begin
      chk("access_len", enRun, eff_w(cur) + 1);
      curValid = 1'b0;
    end
  end

  initial begin
    int nr;
    int i;
    rv = '0;
    rwr = '0;
    for (int n = 0; n < 2; n++) begin
      ra[n] = '0;
      rw[n] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 1'b0);
    chk("rst_enable", enable, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_addr", addr, '0);
    chk("rst_wdata", wData, '0);
    chk("rst_rspv", {s1v, s0v}, 2'b00);
    chk("rst_rsperr", {s1e, s0e}, 2'b00);
    chk("rst_rsp0d", s0d, '0);
    chk("rst_rsp1d", s1d, '0);
    chk("rst_ready", {r1rdy, r0rdy}, 2'b00);
    nReset = 1'b1;

    raise(0, 32'h4, 32'hA5, 1'b1, 0, 32'hDEAD, 1'b0);
    drain(20);

    raise(1, 32'h8, 32'h0, 1'b0, 2, 32'h1234, 1'b0);
    drain(20);

    grants.delete();
    raise(0, 32'h100, 32'h11, 1'b1, 0, 32'h0, 1'b0);
    raise(1, 32'h200, 32'h22, 1'b0, 1, 32'h2222, 1'b0);
    nr = 2;
    i = 0;
    while (grants.size() < 4 && i < 60) begin
      step();
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && nr < 4) begin
          raise(n, 32'h300 + nr, 32'h30 + nr, 1'(nr % 2),
                0, 32'h3000 + nr, 1'b0);
          nr++;
        end
      end
      i++;
    end
    drain(30);
    chk("rr_count", grants.size(), 4);
    for (int g = 0; g < 4; g++) begin
      if (g < grants.size()) chk("rr_order", grants[g], g % 2);
    end

    raise(0, 32'h40, 32'h0, 1'b0, 1, 32'hBEEF, 1'b1);
    drain(20);

    raise(0, 32'h44, 32'h5, 1'b0, 9, 32'hCAFE, 1'b0);
    drain(20);
    chk("tmo_idle", sel, 1'b0);

    raise(0, 32'h10, 32'h77, 1'b0, 3, 32'h99, 1'b0);
    i = 0;
    while (!enable && i < 10) begin
      step();
      i++;
    end
    chk("reach_access", enable, 1'b1);
    nReset = 1'b0;
    exp_q0.delete();
    plan_q.delete();
    step();
    chk("rst_mid_sel", sel, 1'b0);
    chk("rst_mid_enable", enable, 1'b0);
    last_g = 1;
    grants.delete();
    rv = '0;
    raise(1, 32'h60, 32'h6, 1'b1, 0, 32'h0, 1'b0);
    raise(0, 32'h50, 32'h5, 1'b1, 0, 32'h0, 1'b0);
    step();
    nReset = 1'b1;
    step();
    drain(30);
    chk("post_rst_first", (grants.size() > 0) ? grants[0] : -1, 0);

    for (int c = 0; c < 300; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && $urandom_range(0, 2) == 0) rand_raise(n);
        else if (rv[n] && $urandom_range(0, 15) == 0) rv[n] = 1'b0;
      end
      step();
    end
    drain(100);
    chk("plan_left", plan_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
